// File: rtl/mult_sequencer.sv
// Front-end controller for a sequential multiplier: takes one operand pair,
// pulses start, waits (with a watchdog) for finished, and holds the result.
module mult_sequencer #(
    parameter int N       = 8,
    parameter int P       = 16,
    parameter int TIMEOUT = 64,
    parameter int CW      = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    output logic          mul_start,
    output logic [N-1:0]  mul_a,
    output logic [N-1:0]  mul_b,
    input  logic [P-1:0]  mul_product,
    input  logic          mul_finished,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [P-1:0]  out_product,
    output logic          out_error,
    output logic          busy,
    output logic [CW-1:0] op_count,
    output logic [1:0]    dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready is high only in IDLE; out_valid is high only in HOLD and its
    // payload (out_product, out_error) stays stable until out_ready is seen.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam int WW = 16;

    state_t        r_state;
    state_t        w_next;
    logic [WW-1:0] r_wdog;
    logic [N-1:0]  r_mul_a;
    logic [N-1:0]  r_mul_b;
    logic [P-1:0]  r_product;
    logic          r_error;
    logic [CW-1:0] r_count;
    logic          w_timeout;

    assign w_timeout = (r_wdog == WW'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT:  if (mul_finished || w_timeout) w_next = S_HOLD;
            S_HOLD:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Finished takes priority over the watchdog when both land on one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wdog    <= '0;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_product <= '0;
            r_error   <= 1'b0;
            r_count   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mul_a <= in_a;
                        r_mul_b <= in_b;
                    end
                end
                S_START: r_wdog <= '0;
                S_WAIT: begin
                    r_wdog <= r_wdog + WW'(1);
                    if (mul_finished) begin
                        r_product <= mul_product;
                        r_error   <= 1'b0;
                    end else if (w_timeout) begin
                        r_product <= '0;
                        r_error   <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) r_count <= r_count + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign mul_start   = (r_state == S_START);
    assign out_valid   = (r_state == S_HOLD);
    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign out_product = r_product;
    assign out_error   = r_error;
    assign op_count    = r_count;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: transaction-level reference model compared every
// cycle, a simple multiplier responder, and directed scenarios with literal checks.
module tb_mult_sequencer;

    localparam int N       = 8;
    localparam int P       = 16;
    localparam int TIMEOUT = 64;
    localparam int CW      = 2;

    logic          clock     = 1'b0;
    logic          reset     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [N-1:0]  in_a      = '0;
    logic [N-1:0]  in_b      = '0;
    logic          resp_fin  = 1'b0;
    logic          spur_fin  = 1'b0;
    logic [P-1:0]  resp_prod = '0;
    logic          mul_finished;
    logic [P-1:0]  mul_product;

    logic          in_ready;
    logic          mul_start;
    logic [N-1:0]  mul_a;
    logic [N-1:0]  mul_b;
    logic          out_valid;
    logic [P-1:0]  out_product;
    logic          out_error;
    logic          busy;
    logic [CW-1:0] op_count;
    logic [1:0]    dbg_state;

    int checks   = 0;
    int failures = 0;
    int fin_delay = 0;
    int rem = 0;
    bit cmp_en = 1'b0;

    assign mul_finished = resp_fin | spur_fin;
    assign mul_product  = resp_prod;

    mult_sequencer #(.N(N), .P(P), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_product(mul_product), .mul_finished(mul_finished),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_error(out_error),
        .busy(busy), .op_count(op_count), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Multiplier stand-in: finished pulses fin_delay cycles after the start
    // cycle (fin_delay = 0 means it never finishes).
    always @(negedge clock) begin
        resp_fin = 1'b0;
        if (rem > 0) begin
            rem--;
            if (rem == 0) resp_fin = 1'b1;
        end
        if (mul_start === 1'b1) begin
            rem = fin_delay;
            resp_prod = P'(mul_a) * P'(mul_b);
        end
    end

    // Reference model: one operation in flight; m_age counts edges since the
    // operand was taken (0 = start cycle, 1..TIMEOUT = waiting cycles).
    bit           m_busy  = 1'b0;
    bit           m_res   = 1'b0;
    int           m_age   = 0;
    int           m_count = 0;
    logic [N-1:0] m_a     = '0;
    logic [N-1:0] m_b     = '0;
    logic [P-1:0] m_prod  = '0;
    logic         m_err   = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0; m_res = 1'b0; m_age = 0; m_count = 0;
            m_a = '0; m_b = '0; m_prod = '0; m_err = 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1'b1; m_res = 1'b0; m_age = 0; m_a = in_a; m_b = in_b;
            end
        end else if (m_res) begin
            if (out_ready) begin
                m_busy = 1'b0;
                m_count = (m_count + 1) % (1 << CW);
            end
        end else begin
            if (m_age >= 1 && mul_finished) begin
                m_res = 1'b1; m_prod = P'(m_a) * P'(m_b); m_err = 1'b0;
            end else if (m_age == TIMEOUT) begin
                m_res = 1'b1; m_prod = '0; m_err = 1'b1;
            end
            m_age++;
        end
    end

    always @(negedge clock) begin
        if (cmp_en && !reset) begin
            chk("in_ready",    32'(in_ready),    32'(!m_busy));
            chk("busy",        32'(busy),        32'(m_busy));
            chk("mul_start",   32'(mul_start),   32'(m_busy && !m_res && m_age == 0));
            chk("out_valid",   32'(out_valid),   32'(m_busy && m_res));
            chk("out_product", 32'(out_product), 32'(m_prod));
            chk("out_error",   32'(out_error),   32'(m_err));
            chk("op_count",    32'(op_count),    32'(m_count));
            chk("mul_a",       32'(mul_a),       32'(m_a));
            chk("mul_b",       32'(mul_b),       32'(m_b));
        end
    end

    int           lat;
    logic [P-1:0] prod;
    logic         err;

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int delay,
                          input int hold, output int l, output logic [P-1:0] p, output logic e);
        fin_delay = delay;
        @(negedge clock);
        in_a = a; in_b = b; in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        l = 1;
        while (!out_valid && l < 200) begin
            @(negedge clock);
            l++;
        end
        if (!out_valid) chk("wait_out_valid", 32'(out_valid), 32'd1);
        p = out_product;
        e = out_error;
        repeat (hold) @(negedge clock);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    int exp_seq[5] = '{1, 2, 3, 0, 1};
    int got_seq[5];
    int n_done;
    int k;
    int guard;
    bit prev_valid;

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_mul_start", 32'(mul_start), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_op_count",  32'(op_count), 32'd0);
        chk("rst_product",   32'(out_product), 32'd0);
        chk("rst_error",     32'(out_error), 32'd0);
        chk("rst_mul_a",     32'(mul_a), 32'd0);
        chk("rst_mul_b",     32'(mul_b), 32'd0);
        cmp_en = 1'b1;

        run_op(8'h0D, 8'h09, 5, 0, lat, prod, err);
        chk("basic_latency", 32'(lat), 32'd7);
        chk("basic_product", 32'(prod), 32'h0075);
        chk("basic_error",   32'(err), 32'd0);
        chk("basic_count",   32'(op_count), 32'd1);

        run_op(8'hFF, 8'hFF, 3, 10, lat, prod, err);
        chk("bp_product", 32'(prod), 32'hFE01);
        chk("bp_stable",  32'(out_product), 32'hFE01);
        chk("bp_error",   32'(err), 32'd0);
        chk("bp_count",   32'(op_count), 32'd2);

        run_op(8'h21, 8'h42, 0, 0, lat, prod, err);
        chk("to_latency", 32'(lat), 32'd66);
        chk("to_product", 32'(prod), 32'd0);
        chk("to_error",   32'(err), 32'd1);
        chk("to_count",   32'(op_count), 32'd3);

        run_op(8'd3, 8'd4, 2, 0, lat, prod, err);
        chk("after_to_latency", 32'(lat), 32'd4);
        chk("after_to_product", 32'(prod), 32'd12);
        chk("after_to_error",   32'(err), 32'd0);
        chk("after_to_count",   32'(op_count), 32'd0);

        run_op(8'h12, 8'h34, 64, 0, lat, prod, err);
        chk("tie_latency", 32'(lat), 32'd66);
        chk("tie_product", 32'(prod), 32'h03A8);
        chk("tie_error",   32'(err), 32'd0);
        chk("tie_count",   32'(op_count), 32'd1);

        // Reset while the start pulse is high.
        fin_delay = 0;
        @(negedge clock);
        in_a = 8'h07; in_b = 8'h08; in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_start_mul_start", 32'(mul_start), 32'd0);
        chk("rst_start_busy",      32'(busy), 32'd0);
        chk("rst_start_count",     32'(op_count), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Reset while waiting; the late finished must be ignored.
        fin_delay = 20;
        @(negedge clock);
        in_a = 8'h05; in_b = 8'h06; in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (4) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rst_wait_mul_start", 32'(mul_start), 32'd0);
        chk("rst_wait_out_valid", 32'(out_valid), 32'd0);
        chk("rst_wait_busy",      32'(busy), 32'd0);
        chk("rst_wait_in_ready",  32'(in_ready), 32'd1);
        chk("rst_wait_mul_a",     32'(mul_a), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        chk("late_fin_out_valid", 32'(out_valid), 32'd0);
        chk("late_fin_busy",      32'(busy), 32'd0);

        // Back-to-back with in_valid and out_ready held high; op_count wraps.
        fin_delay = 3;
        out_ready = 1'b1;
        in_valid = 1'b1;
        n_done = 0; k = 0; guard = 0; prev_valid = 1'b0;
        while (n_done < 5 && guard < 300) begin
            @(negedge clock);
            guard++;
            k++;
            in_a = 8'(k * 7 + 1);
            in_b = 8'(k * 3 + 2);
            if (prev_valid) begin
                got_seq[n_done] = int'(op_count);
                n_done++;
            end
            prev_valid = out_valid;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("wrap_ops_done", 32'(n_done), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < n_done) chk($sformatf("wrap_count_%0d", i), 32'(got_seq[i]), 32'(exp_seq[i]));
        end

        // Spurious finished pulses while idle.
        @(negedge clock);
        spur_fin = 1'b1;
        repeat (3) @(negedge clock);
        spur_fin = 1'b0;
        repeat (3) @(negedge clock);
        chk("spur_out_valid", 32'(out_valid), 32'd0);
        chk("spur_busy",      32'(busy), 32'd0);
        chk("spur_count",     32'(op_count), 32'd1);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
